// File: rtl/cacheline_adaptor.sv
// Bridges a cache that moves whole lines to a memory that moves fixed-width beats:
// line fills are assembled from read beats, writebacks are split into write beats.
module cacheline_adaptor #(
    parameter int s_line  = 256,
    parameter int s_burst = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [s_line-1:0]  line_i,
    output logic [s_line-1:0]  line_o,
    input  logic [31:0]        address_i,
    input  logic               read_i,
    input  logic               write_i,
    output logic               resp_o,
    input  logic [s_burst-1:0] burst_i,
    output logic [s_burst-1:0] burst_o,
    output logic [31:0]        address_o,
    output logic               read_o,
    output logic               write_o,
    input  logic               resp_i
);

    localparam int BEATS = s_line / s_burst;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFS_W = $clog2(s_line / 8);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [31:OFS_W]        addr_q, addr_d;
    logic [s_line-1:0]      wline_q, wline_d;
    logic [s_line-1:0]      rline_q, rline_d;

    // NOTE: every signal written here gets its hold value first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wline_d = wline_q;
        rline_d = rline_q;

        unique case (state_q)
            IDLE: begin
                if (write_i) begin
                    state_d = WRITE;
                    cnt_d   = '0;
                    addr_d  = address_i[31:OFS_W];
                    wline_d = line_i;
                end else if (read_i) begin
                    state_d = READ;
                    cnt_d   = '0;
                    addr_d  = address_i[31:OFS_W];
                end
            end
            READ: begin
                if (resp_i) begin
                    for (int b = 0; b < BEATS; b++) begin
                        if (cnt_q == CNT_W'(b)) rline_d[b*s_burst +: s_burst] = burst_i;
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BEAT) state_d = DONE;
                end
            end
            WRITE: begin
                if (resp_i) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BEAT) state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Beat mux for writes; the bus is held at zero whenever no write burst is in flight.
    always_comb begin
        burst_o = '0;
        if (state_q == WRITE) begin
            for (int b = 0; b < BEATS; b++) begin
                if (cnt_q == CNT_W'(b)) burst_o = wline_q[b*s_burst +: s_burst];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wline_q <= '0;
            rline_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wline_q <= wline_d;
            rline_q <= rline_d;
        end
    end

    assign line_o    = rline_q;
    assign address_o = {addr_q, {OFS_W{1'b0}}};
    assign read_o    = (state_q == READ);
    assign write_o   = (state_q == WRITE);
    assign resp_o    = (state_q == DONE);

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Transaction-level bench for cacheline_adaptor: directed scenarios plus randomized
// fills/writebacks with random memory wait states, checked against per-transaction expectations.
module tb_cacheline_adaptor;

    localparam int LW = 256;
    localparam int BW = 64;
    localparam int NB = LW / BW;

    logic          clk = 1'b0;
    logic          rst;
    logic [LW-1:0] line_i, line_o;
    logic [31:0]   address_i, address_o;
    logic          read_i, write_i, resp_o, read_o, write_o, resp_i;
    logic [BW-1:0] burst_i, burst_o;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [LW-1:0] model_line;
    bit            resp_pat[$];
    logic [BW-1:0] beat_pat[$];
    logic [BW-1:0] acc_q[$];

    cacheline_adaptor #(.s_line(LW), .s_burst(BW)) dut (
        .clk       (clk),
        .rst       (rst),
        .line_i    (line_i),
        .line_o    (line_o),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .resp_o    (resp_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .resp_i    (resp_i)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] r;
        for (int i = 0; i < LW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Runs one transaction starting just after a negedge with the DUT idle.
    task automatic run_txn(input bit wr, input bit both, input logic [31:0] addr,
                           input logic [LW-1:0] wline, input int wait_pct,
                           input bit hold_after, input logic [31:0] next_addr);
        logic [LW-1:0] exp_line;
        logic [BW-1:0] beat, exp_b;
        logic [31:0]   exp_addr;
        int            k, waits, cyc;
        bit            r;
        exp_addr = addr & 32'hFFFF_FFE0;
        exp_line = wr ? model_line : '0;
        read_i = !wr || both; write_i = wr; address_i = addr; line_i = wline;
        @(negedge clk);
        line_i = rand_line();
        address_i = $urandom;
        k = 0; waits = 0; cyc = 0;
        while (k < NB && cyc < 64) begin
            exp_b = wr ? BW'(wline >> (BW * k)) : '0;
            check(wr ? "wr_write_o" : "rd_read_o", wr ? write_o : read_o, 1'b1);
            check("txn_other_req", wr ? read_o : write_o, 1'b0);
            check("txn_resp_o", resp_o, 1'b0);
            check("txn_address_o", address_o, exp_addr);
            check("txn_burst_o", burst_o, exp_b);
            read_i  = 1'($urandom_range(0, 1));
            write_i = 1'($urandom_range(0, 1));
            if (resp_pat.size() > 0) r = resp_pat.pop_front();
            else r = ($urandom_range(0, 99) >= wait_pct) || (waits >= 5);
            resp_i = r;
            if (r) begin
                beat = (!wr && beat_pat.size() > 0) ? beat_pat.pop_front() : {$urandom, $urandom};
                burst_i = beat;
                if (wr) acc_q.push_back(burst_o);
                else exp_line = exp_line | (LW'(beat) << (BW * k));
                k++;
                waits = 0;
            end else begin
                burst_i = {$urandom, $urandom};
                waits++;
            end
            cyc++;
            @(negedge clk);
        end
        check("done_resp_o", resp_o, 1'b1);
        check("done_read_o", read_o, 1'b0);
        check("done_write_o", write_o, 1'b0);
        check("done_burst_o", burst_o, '0);
        check("done_line_o", line_o, exp_line);
        model_line = exp_line;
        read_i = hold_after; write_i = 1'b0; address_i = next_addr;
        resp_i = 1'($urandom_range(0, 1));
        burst_i = {$urandom, $urandom};
        @(negedge clk);
        check("idle_resp_o", resp_o, 1'b0);
        check("idle_read_o", read_o, 1'b0);
        check("idle_write_o", write_o, 1'b0);
        check("idle_line_o", line_o, model_line);
        resp_i = 1'b0;
    endtask

    task automatic spurious_idle(input bit addr_zero);
        read_i = 1'b0; write_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            resp_i = 1'b1;
            burst_i = {$urandom, $urandom};
            @(negedge clk);
            check("sp_read_o", read_o, 1'b0);
            check("sp_write_o", write_o, 1'b0);
            check("sp_resp_o", resp_o, 1'b0);
            check("sp_burst_o", burst_o, '0);
            check("sp_line_o", line_o, model_line);
            if (addr_zero) check("sp_address_o", address_o, '0);
        end
        resp_i = 1'b0;
    endtask

    task automatic reset_mid_read();
        read_i = 1'b1; write_i = 1'b0; address_i = $urandom;
        @(negedge clk);
        read_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            resp_i = 1'b1;
            burst_i = {$urandom, $urandom};
            @(negedge clk);
        end
        rst = 1'b0; read_i = 1'b1; write_i = 1'b1; resp_i = 1'b1;
        @(negedge clk);
        check("abort_read_o", read_o, 1'b0);
        check("abort_write_o", write_o, 1'b0);
        check("abort_resp_o", resp_o, 1'b0);
        check("abort_line_o", line_o, '0);
        check("abort_burst_o", burst_o, '0);
        check("abort_address_o", address_o, '0);
        rst = 1'b1; read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
        model_line = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("abort_no_resp", resp_o, 1'b0);
            check("abort_stay_idle", read_o | write_o, 1'b0);
        end
    endtask

    initial begin
        logic [31:0] a2;
        bit          wr;
        rst = 1'b0; read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
        line_i = '0; address_i = '0; burst_i = '0;
        model_line = '0;
        repeat (2) @(negedge clk);
        check("rst_resp_o", resp_o, 1'b0);
        check("rst_read_o", read_o, 1'b0);
        check("rst_write_o", write_o, 1'b0);
        check("rst_burst_o", burst_o, '0);
        check("rst_address_o", address_o, '0);
        check("rst_line_o", line_o, '0);
        rst = 1'b1;
        @(negedge clk);
        spurious_idle(1'b1);

        // Directed zero-wait line fill.
        beat_pat = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                     64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
        run_txn(1'b0, 1'b0, 32'h1234_5678, '0, 0, 1'b0, '0);
        check("fill_line", line_o, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                    64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});

        // Directed writeback with memory wait states.
        acc_q.delete();
        resp_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        run_txn(1'b1, 1'b0, 32'h0000_0040,
                {64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB,
                 64'hCCCC_CCCC_CCCC_CCCC, 64'hDDDD_DDDD_DDDD_DDDD}, 0, 1'b0, '0);
        check("wb_beats", LW'(acc_q.size()), LW'(4));
        if (acc_q.size() == 4) begin
            check("wb_beat0", acc_q[0], 64'hDDDD_DDDD_DDDD_DDDD);
            check("wb_beat1", acc_q[1], 64'hCCCC_CCCC_CCCC_CCCC);
            check("wb_beat2", acc_q[2], 64'hBBBB_BBBB_BBBB_BBBB);
            check("wb_beat3", acc_q[3], 64'hAAAA_AAAA_AAAA_AAAA);
        end

        // Simultaneous read and write request: write wins.
        run_txn(1'b1, 1'b1, $urandom, rand_line(), 30, 1'b0, '0);
        spurious_idle(1'b0);

        // Back-to-back fills with the request held across resp_o.
        a2 = $urandom;
        run_txn(1'b0, 1'b0, $urandom, '0, 20, 1'b1, a2);
        run_txn(1'b0, 1'b0, a2, '0, 20, 1'b0, '0);

        reset_mid_read();

        for (int t = 0; t < 30; t++) begin
            wr = 1'($urandom_range(0, 1));
            run_txn(wr, wr & 1'($urandom_range(0, 1)), $urandom, rand_line(),
                    $urandom_range(0, 60), 1'b0, '0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
